// File: rtl/damage_coprocessor_pkg.sv
// Shared definitions for the damage coprocessor: FSM state encoding,
// attack-word bit positions, decoded attack classes and the damage table.
// The bit positions and damage values are the ones the attack unit on the
// opponent side produces, so both sides stay in agreement.
package damage_coprocessor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LATCH   = 2'd1,
    ST_STUN    = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ATK_NONE     = 3'd0,
    ATK_JAB      = 3'd1,
    ATK_NSPECIAL = 3'd2,
    ATK_SPECIAL  = 3'd3,
    ATK_SMASH    = 3'd4
  } atk_e;

  // Opponent attack word layout
  localparam int unsigned ATK_HIT_BIT    = 0;
  localparam int unsigned ATK_SMASH_LO   = 1;   // smash U/D/L/R = [1..4]
  localparam int unsigned ATK_SMASH_HI   = 4;
  localparam int unsigned ATK_JAB_BIT    = 5;
  localparam int unsigned ATK_SPEC_LO    = 6;   // special U/D/L/R = [6..9]
  localparam int unsigned ATK_SPEC_HI    = 9;
  localparam int unsigned ATK_NSPEC_BIT  = 10;
  localparam int unsigned ATK_ACTIVE_BIT = 11;

  // Damage applied per attack class
  localparam logic [9:0] DMG_SMASH    = 10'd15;
  localparam logic [9:0] DMG_SPECIAL  = 10'd10;
  localparam logic [9:0] DMG_NSPECIAL = 10'd8;
  localparam logic [9:0] DMG_JAB      = 10'd3;

  // Priority: smash > directional special > neutral special > jab
  function automatic atk_e classify_attack(input logic [3:0] smash,
                                           input logic [3:0] special,
                                           input logic       nspecial,
                                           input logic       jab);
    atk_e t;
    if (|smash)        t = ATK_SMASH;
    else if (|special) t = ATK_SPECIAL;
    else if (nspecial) t = ATK_NSPECIAL;
    else if (jab)      t = ATK_JAB;
    else               t = ATK_NONE;
    return t;
  endfunction

  function automatic logic [9:0] damage_of(input atk_e t);
    logic [9:0] d;
    case (t)
      ATK_SMASH:    d = DMG_SMASH;
      ATK_SPECIAL:  d = DMG_SPECIAL;
      ATK_NSPECIAL: d = DMG_NSPECIAL;
      ATK_JAB:      d = DMG_JAB;
      default:      d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/knockback_scaler.sv
// Combinational knockback scaler for one axis.
//   kb      in  16  signed knockback component
//   damage  in  10  unsigned damage percent before the hit
//   scaled  out 16  signed launch component, saturated to [-32768, 32767]
// scaled = kb + floor(kb * damage / 2**KB_SHIFT)
module knockback_scaler #(
  parameter int unsigned KB_SHIFT = 7
) (
  input  logic [15:0] kb,
  input  logic [9:0]  damage,
  output logic [15:0] scaled
);

  logic signed [26:0] kb_ext;
  logic signed [26:0] dmg_ext;
  logic signed [26:0] product;
  logic signed [26:0] shifted;
  logic signed [27:0] sum;

  assign kb_ext  = {{11{kb[15]}}, kb};
  assign dmg_ext = {17'd0, damage};
  assign product = kb_ext * dmg_ext;
  assign shifted = product >>> KB_SHIFT;

  // The sum is carried at full product width so high damage saturates
  // instead of wrapping around before the clamp.
  assign sum = {shifted[26], shifted} + {{12{kb[15]}}, kb};

  always_comb begin
    scaled = sum[15:0];
    if (sum > 28'sd32767)       scaled = 16'h7FFF;
    else if (sum < -28'sd32768) scaled = 16'h8000;
  end

endmodule

// File: rtl/damage_coprocessor.sv
// Receive-side damage coprocessor for one character. Detects opponent hit
// edges, accumulates damage, scales the opponent's knockback by the damage
// held before the hit into a launch vector, and runs a hitstun timer.
//   clock          in   1   system clock
//   reset          in   1   asynchronous active-low reset
//   opp_attack     in   32  opponent attack word ([0] hit, [11] attack active)
//   opp_knockback  in   32  opponent knockback {X, Y}, valid one clock after type
//   my_shield      in   1   own shield active
//   respawn        in   1   synchronous clear of damage and hit processing
//   damage         out  10  damage percent, saturating at DAMAGE_MAX
//   launch         out  32  scaled knockback {X, Y}, nonzero only in stun
//   hitstun        out  1   high while stunned
//   hit_pulse      out  1   one clock when a hit is applied
//   blocked_pulse  out  1   one clock when a hit edge meets an active shield
module damage_coprocessor
  import damage_coprocessor_pkg::*;
#(
  parameter logic [21:0] HITSTUN_CYCLES = 22'h200000,
  parameter logic [9:0]  DAMAGE_MAX     = 10'd999,
  parameter int unsigned KB_SHIFT       = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] opp_attack,
  input  logic [31:0] opp_knockback,
  input  logic        my_shield,
  input  logic        respawn,
  output logic [9:0]  damage,
  output logic [31:0] launch,
  output logic        hitstun,
  output logic        hit_pulse,
  output logic        blocked_pulse
);

  state_e      state_q, state_d;
  atk_e        type_q, type_d;
  logic        prev_hit_q;
  logic [9:0]  damage_q, damage_d;
  logic [31:0] launch_q, launch_d;
  logic        hitstun_q, hitstun_d;
  logic        hit_pulse_q, hit_pulse_d;
  logic        blocked_q, blocked_d;
  logic [21:0] cnt_q, cnt_d;

  logic        hit_edge;
  logic [15:0] scaled_x, scaled_y;
  logic [10:0] dmg_sum;
  logic        unused_attack_bits;

  assign unused_attack_bits = ^opp_attack[31:12];

  assign hit_edge = opp_attack[ATK_HIT_BIT] & ~prev_hit_q & opp_attack[ATK_ACTIVE_BIT];

  knockback_scaler #(.KB_SHIFT(KB_SHIFT)) u_scale_x (
    .kb     (opp_knockback[31:16]),
    .damage (damage_q),
    .scaled (scaled_x)
  );

  knockback_scaler #(.KB_SHIFT(KB_SHIFT)) u_scale_y (
    .kb     (opp_knockback[15:0]),
    .damage (damage_q),
    .scaled (scaled_y)
  );

  assign dmg_sum = {1'b0, damage_q} + {1'b0, damage_of(type_q)};

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    damage_d    = damage_q;
    launch_d    = launch_q;
    hitstun_d   = hitstun_q;
    cnt_d       = cnt_q;
    hit_pulse_d = 1'b0;
    blocked_d   = 1'b0;

    if (respawn) begin
      state_d   = ST_IDLE;
      damage_d  = '0;
      launch_d  = '0;
      hitstun_d = 1'b0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hit_edge) begin
            if (my_shield) begin
              blocked_d = 1'b1;
              state_d   = ST_RECOVER;
            end else begin
              type_d  = classify_attack(opp_attack[ATK_SMASH_HI:ATK_SMASH_LO],
                                        opp_attack[ATK_SPEC_HI:ATK_SPEC_LO],
                                        opp_attack[ATK_NSPEC_BIT],
                                        opp_attack[ATK_JAB_BIT]);
              state_d = ST_LATCH;
            end
          end
        end
        ST_LATCH: begin
          // Scalers see damage_q, i.e. the damage before this hit lands.
          launch_d    = {scaled_x, scaled_y};
          damage_d    = (dmg_sum > {1'b0, DAMAGE_MAX}) ? DAMAGE_MAX : dmg_sum[9:0];
          hit_pulse_d = 1'b1;
          hitstun_d   = 1'b1;
          cnt_d       = HITSTUN_CYCLES - 22'd1;
          state_d     = ST_STUN;
        end
        ST_STUN: begin
          if (cnt_q == '0) begin
            launch_d  = '0;
            hitstun_d = 1'b0;
            state_d   = ST_RECOVER;
          end else begin
            cnt_d = cnt_q - 22'd1;
          end
        end
        ST_RECOVER: begin
          if (!opp_attack[ATK_ACTIVE_BIT]) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      type_q      <= ATK_NONE;
      prev_hit_q  <= 1'b0;
      damage_q    <= '0;
      launch_q    <= '0;
      hitstun_q   <= 1'b0;
      hit_pulse_q <= 1'b0;
      blocked_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      prev_hit_q  <= opp_attack[ATK_HIT_BIT];
      damage_q    <= damage_d;
      launch_q    <= launch_d;
      hitstun_q   <= hitstun_d;
      hit_pulse_q <= hit_pulse_d;
      blocked_q   <= blocked_d;
      cnt_q       <= cnt_d;
    end
  end

  assign damage        = damage_q;
  assign launch        = launch_q;
  assign hitstun       = hitstun_q;
  assign hit_pulse     = hit_pulse_q;
  assign blocked_pulse = blocked_q;

endmodule

// File: tb/tb_damage_coprocessor.sv
module tb_damage_coprocessor;

  localparam logic [21:0] HS       = 22'd8;
  localparam int          HS_INT   = 8;
  localparam int          DMAX     = 999;
  localparam longint      SCALE_DV = 128;

  localparam int MODE_NONE    = 0;
  localparam int MODE_RESET   = 1;
  localparam int MODE_RESPAWN = 2;
  localparam int MODE_SHIELD  = 3;

  localparam logic [31:0] W_SMASH_U = 32'h0000_0803;
  localparam logic [31:0] W_SMASH_L = 32'h0000_0809;
  localparam logic [31:0] W_SPEC_U  = 32'h0000_0841;
  localparam logic [31:0] W_SPEC_D  = 32'h0000_0881;
  localparam logic [31:0] W_BARE    = 32'h0000_0801;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] opp_attack;
  logic [31:0] opp_knockback;
  logic        my_shield;
  logic        respawn;
  logic [9:0]  damage;
  logic [31:0] launch;
  logic        hitstun;
  logic        hit_pulse;
  logic        blocked_pulse;

  damage_coprocessor #(
    .HITSTUN_CYCLES (HS),
    .DAMAGE_MAX     (10'd999),
    .KB_SHIFT       (7)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .opp_attack    (opp_attack),
    .opp_knockback (opp_knockback),
    .my_shield     (my_shield),
    .respawn       (respawn),
    .damage        (damage),
    .launch        (launch),
    .hitstun       (hitstun),
    .hit_pulse     (hit_pulse),
    .blocked_pulse (blocked_pulse)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [9:0]  exp_damage;
  logic [31:0] exp_launch;
  logic        exp_hitstun;
  logic        exp_hit_pulse;
  logic        exp_blocked;
  bit          cmp_en = 1'b0;

  logic [31:0] seen_launch;
  logic [9:0]  seen_damage;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("damage",        32'(damage),        32'(exp_damage));
      chk("launch",        launch,             exp_launch);
      chk("hitstun",       32'(hitstun),       32'(exp_hitstun));
      chk("hit_pulse",     32'(hit_pulse),     32'(exp_hit_pulse));
      chk("blocked_pulse", 32'(blocked_pulse), 32'(exp_blocked));
    end
  end

  // Reference scaling: kb + floor(kb*damage/128), clamped to 16-bit signed.
  function automatic logic [15:0] model_axis(input logic [15:0] kb, input int dmg);
    longint k, p, q, s;
    k = longint'($signed(kb));
    p = k * longint'(dmg);
    q = p / SCALE_DV;
    if (p < 0 && q * SCALE_DV != p) q = q - 1;
    s = k + q;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  function automatic int model_dmg(input logic [31:0] w);
    if (|w[4:1])      return 15;
    else if (|w[9:6]) return 10;
    else if (w[10])   return 8;
    else if (w[5])    return 3;
    else              return 0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic zero_expect(input bit clear_damage);
    exp_launch    = '0;
    exp_hitstun   = 1'b0;
    exp_hit_pulse = 1'b0;
    exp_blocked   = 1'b0;
    if (clear_damage) exp_damage = '0;
  endtask

  // Drives one attack: word after edge T, knockback after T+1; results after T+2.
  task automatic hit(input logic [31:0] word, input logic [31:0] kb, input bit shield,
                     input int mode, input int at_k);
    int nd;
    tick();
    opp_attack = word;
    my_shield  = shield;
    tick();
    opp_knockback = kb;
    if (shield) begin
      exp_blocked = 1'b1;
      tick();
      exp_blocked = 1'b0;
      my_shield   = 1'b0;
      return;
    end
    tick();
    exp_launch = {model_axis(kb[31:16], int'(exp_damage)), model_axis(kb[15:0], int'(exp_damage))};
    nd = int'(exp_damage) + model_dmg(word);
    if (nd > DMAX) nd = DMAX;
    exp_damage    = 10'(nd);
    exp_hit_pulse = 1'b1;
    exp_hitstun   = 1'b1;
    seen_launch   = launch;
    seen_damage   = damage;
    for (int k = 1; k < HS_INT; k++) begin
      tick();
      exp_hit_pulse = 1'b0;
      if (k == at_k) begin
        if (mode == MODE_RESET) begin
          reset      = 1'b0;
          opp_attack = '0;
          zero_expect(1'b1);
          #1;
          chk("async_reset_damage",  32'(damage),  32'd0);
          chk("async_reset_hitstun", 32'(hitstun), 32'd0);
          chk("async_reset_launch",  launch,       32'd0);
          tick();
          reset = 1'b1;
          return;
        end else if (mode == MODE_RESPAWN) begin
          respawn = 1'b1;
          tick();
          respawn    = 1'b0;
          opp_attack = '0;
          zero_expect(1'b1);
          return;
        end else if (mode == MODE_SHIELD) begin
          my_shield = 1'b1;
        end
      end
    end
    tick();
    exp_hitstun = 1'b0;
    exp_launch  = '0;
    my_shield   = 1'b0;
  endtask

  task automatic release_attack();
    opp_attack    = '0;
    opp_knockback = '0;
    tick();
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    opp_attack    = '0;
    opp_knockback = '0;
    my_shield     = 1'b0;
    respawn       = 1'b0;
    zero_expect(1'b1);
    #2 reset = 1'b0;
    #1 cmp_en = 1'b1;
    chk("reset_damage",  32'(damage),        32'd0);
    chk("reset_launch",  launch,             32'd0);
    chk("reset_pulses",  32'({hit_pulse, blocked_pulse, hitstun}), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // 1: async reset in the middle of stun, then quiet
    hit(W_SMASH_U, 32'h0000_0800, 1'b0, MODE_RESET, 3);
    repeat (4) tick();

    // 2: smash up from zero damage
    hit(W_SMASH_U, 32'h0000_0800, 1'b0, MODE_NONE, 0);
    chk("t2_launch", seen_launch, 32'h0000_0800);
    chk("t2_damage", 32'(seen_damage), 32'd15);
    release_attack();

    // 3: smash left at damage 15; shield rising mid-stun has no effect
    hit(W_SMASH_L, 32'hF7FE_00A0, 1'b0, MODE_SHIELD, 3);
    chk("t3_launch", seen_launch, 32'hF70D_00B2);
    chk("t3_damage", 32'(seen_damage), 32'd30);
    release_attack();

    // 4: blocked hit; new hit edges ignored while the attack stays active
    hit(W_SMASH_U, 32'h1234_5678, 1'b1, MODE_NONE, 0);
    tick();
    opp_attack = W_SMASH_U & ~32'h1;
    tick();
    opp_attack = W_SMASH_U;
    repeat (3) tick();
    chk("t4_damage", 32'(damage), 32'd30);
    release_attack();

    // 5: hit bit held long past stun gives a single increment
    hit(W_SPEC_D, 32'h0000_0000, 1'b0, MODE_NONE, 0);
    repeat (100) tick();
    opp_attack = W_SPEC_D & ~32'h1;
    tick();
    opp_attack = W_SPEC_D;
    repeat (3) tick();
    chk("t5_damage", 32'(damage), 32'd40);
    release_attack();

    // 7: hit with no type bits: no damage, launch still scaled
    hit(W_BARE, 32'h0100_FF00, 1'b0, MODE_NONE, 0);
    chk("t7_launch", seen_launch, 32'h0150_FEB0);
    chk("t7_damage", 32'(seen_damage), 32'd40);
    release_attack();

    // respawn while idle
    respawn = 1'b1;
    tick();
    respawn    = 1'b0;
    exp_damage = '0;
    chk("respawn_idle_damage", 32'(damage), 32'd0);

    // build up to 995: 65 smashes + 2 specials
    for (int i = 0; i < 67; i++) begin
      hit((i < 65) ? W_SMASH_U : W_SPEC_U, 32'h0, 1'b0, MODE_NONE, 0);
      release_attack();
    end
    chk("t6_pre_damage", 32'(damage), 32'd995);

    // 6: saturation of damage and launch, then respawn mid-stun
    hit(W_SMASH_U, 32'h7000_0000, 1'b0, MODE_RESPAWN, 2);
    chk("t6_launch", seen_launch, 32'h7FFF_0000);
    chk("t6_damage", 32'(seen_damage), 32'd999);
    chk("t6_respawn_damage", 32'(damage), 32'd0);
    release_attack();
    repeat (3) tick();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
